// File: rtl/bpu_btb.sv
// Fully associative branch target buffer with optional 2-bit direction counters.
// Define BPU_SAT_CNT_EN to enable the counters; otherwise every valid hit predicts taken.
module bpu_btb #(
  parameter  int ENTRIES = 8,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] if_pc,
  input  logic        ex_br_valid,
  input  logic        ex_br_taken,
  input  logic [31:0] ex_br_target,
  output logic [32:0] bp_bus,
  output logic [32:0] bp_to_ex_bus,
  output logic [32:0] mis_bus
);

  typedef struct packed {
    logic             vld;
    logic [31:0]      pc;
    logic             bp_e;
    logic [31:0]      bp_target;
    logic             hit;
    logic [IDX_W-1:0] hit_idx;
  } stg_t;

  logic [ENTRIES-1:0] v;
  logic [31:0]        tag [ENTRIES];
  logic [31:0]        tgt [ENTRIES];
`ifdef BPU_SAT_CNT_EN
  logic [1:0]         cnt [ENTRIES];
`endif
  logic [IDX_W-1:0]   rr_ptr;

  stg_t it_q, ic_q, id_q, ex_q;
  stg_t it_in, it_look;

  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic             pred;
  logic             bp_e;
  logic [31:0]      bp_target;

  logic             ex_res;
  logic             mis_e;
  logic [31:0]      mis_pc;
  logic             upd;

  logic             tag_hit;
  logic [IDX_W-1:0] tag_idx;
  logic             inv_any;
  logic [IDX_W-1:0] inv_idx;
  logic [IDX_W-1:0] vic;

  logic unused_ok;
  assign unused_ok = stall[5];

  // Lookup of the IT pc; descending scan so the lowest index wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (v[i] && tag[i] == it_q.pc) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

`ifdef BPU_SAT_CNT_EN
  assign pred = hit & cnt[hit_idx][1];
`else
  assign pred = hit;
`endif

  assign bp_e      = ~flush & pred;
  assign bp_target = bp_e ? tgt[hit_idx] : 32'h0;
  assign bp_bus    = {bp_e, bp_target};

  // IT bundle enriched with the lookup result before it moves to IC.
  always_comb begin
    it_look           = it_q;
    it_look.bp_e      = bp_e;
    it_look.bp_target = bp_target;
    it_look.hit       = hit;
    it_look.hit_idx   = hit_idx;
  end

  // Fresh fetch entering IT.
  always_comb begin
    it_in     = '0;
    it_in.vld = 1'b1;
    it_in.pc  = if_pc;
  end

  assign bp_to_ex_bus = {ex_q.bp_e, ex_q.bp_target};

  // Redirect request from the resolved branch in EX.
  always_comb begin
    ex_res = ex_q.vld & ex_br_valid;
    mis_e  = 1'b0;
    mis_pc = 32'h0;
    if (ex_res && !flush) begin
      mis_e = (ex_br_taken != ex_q.bp_e) |
              (ex_br_taken & ex_q.bp_e &
               (ex_br_target != ex_q.bp_target));
      mis_pc = ex_br_taken ? ex_br_target
                           : ex_q.pc + 32'd4;
    end
  end

  assign mis_bus = {mis_e, mis_pc};

  // Register k advances on stall[k]; a stop upstream with k free inserts a bubble.
  function automatic stg_t adv(
    input stg_t cur,
    input stg_t prv,
    input logic stop_prv,
    input logic stop,
    input logic kill
  );
    if (kill)                 adv = '0;
    else if (stop_prv & ~stop) adv = '0;
    else if (~stop)           adv = prv;
    else                      adv = cur;
  endfunction

  // Pipeline metadata registers IT/IC/ID/EX.
  always_ff @(posedge clk) begin
    if (rst) begin
      it_q <= '0;
      ic_q <= '0;
      id_q <= '0;
      ex_q <= '0;
    end else begin
      it_q <= adv(it_q, it_in, stall[0], stall[1],
                  flush | mis_e);
      ic_q <= adv(ic_q, it_look, stall[1], stall[2],
                  flush | mis_e);
      id_q <= adv(id_q, ic_q, stall[2], stall[3],
                  flush | mis_e);
      ex_q <= adv(ex_q, id_q, stall[3], stall[4], flush);
    end
  end

  // Allocation helpers: late tag match and lowest invalid slot.
  always_comb begin
    tag_hit = 1'b0;
    tag_idx = '0;
    inv_any = 1'b0;
    inv_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (v[i] && tag[i] == ex_q.pc) begin
        tag_hit = 1'b1;
        tag_idx = IDX_W'(i);
      end
      if (!v[i]) begin
        inv_any = 1'b1;
        inv_idx = IDX_W'(i);
      end
    end
    vic = tag_hit ? tag_idx :
          inv_any ? inv_idx : rr_ptr;
  end

  assign upd = ex_res & ~flush & ~stall[4];

  // Table training from resolved branches.
  always_ff @(posedge clk) begin
    if (rst) begin
      v      <= '0;
      rr_ptr <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag[i] <= '0;
        tgt[i] <= '0;
`ifdef BPU_SAT_CNT_EN
        cnt[i] <= '0;
`endif
      end
    end else if (upd) begin
      if (ex_q.hit) begin
        if (ex_br_taken) begin
          tgt[ex_q.hit_idx] <= ex_br_target;
`ifdef BPU_SAT_CNT_EN
          if (cnt[ex_q.hit_idx] != 2'b11)
            cnt[ex_q.hit_idx] <= cnt[ex_q.hit_idx] + 2'b01;
`endif
        end else begin
`ifdef BPU_SAT_CNT_EN
          if (cnt[ex_q.hit_idx] != 2'b00)
            cnt[ex_q.hit_idx] <= cnt[ex_q.hit_idx] - 2'b01;
`else
          v[ex_q.hit_idx] <= 1'b0;
`endif
        end
      end else if (ex_br_taken) begin
        v[vic]   <= 1'b1;
        tag[vic] <= ex_q.pc;
        tgt[vic] <= ex_br_target;
`ifdef BPU_SAT_CNT_EN
        cnt[vic] <= 2'b10;
`endif
        if (!tag_hit && !inv_any)
          rr_ptr <= rr_ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bpu_btb.sv
// Directed bench for bpu_btb with a 4-entry table.
// Expected values are hand-derived per step.
module tb_bpu_btb;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] if_pc;
  logic        ex_br_valid;
  logic        ex_br_taken;
  logic [31:0] ex_br_target;
  logic [32:0] bp_bus;
  logic [32:0] bp_to_ex_bus;
  logic [32:0] mis_bus;

  int n_run  = 0;
  int n_fail = 0;

  localparam logic [31:0] FILL = 32'h0000_8000;

  always #5 clk = ~clk;

  bpu_btb #(.ENTRIES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .if_pc        (if_pc),
    .ex_br_valid  (ex_br_valid),
    .ex_br_taken  (ex_br_taken),
    .ex_br_target (ex_br_target),
    .bp_bus       (bp_bus),
    .bp_to_ex_bus (bp_to_ex_bus),
    .mis_bus      (mis_bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [32:0] obs,
                     input logic [32:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    rst   = 1'b1;
    if_pc = 32'h1000;
    tick;
    tick;
    rst   = 1'b0;
    if_pc = FILL;
  endtask

  // Fetch pc, walk it to EX, resolve it there.
  task automatic branch(input string tag,
                        input logic [31:0] pc,
                        input logic tk,
                        input logic [31:0] tg,
                        input logic [32:0] exp_bp,
                        input logic [32:0] exp_mis);
    if_pc = pc;
    tick;
    if_pc = FILL;
    chk({tag, "_bp"}, bp_bus, exp_bp);
    tick;
    tick;
    tick;
    chk({tag, "_bpex"}, bp_to_ex_bus, exp_bp);
    ex_br_valid  = 1'b1;
    ex_br_taken  = tk;
    ex_br_target = tg;
    #1;
    chk({tag, "_mis"}, mis_bus, exp_mis);
    tick;
    ex_br_valid  = 1'b0;
    ex_br_taken  = 1'b0;
    ex_br_target = 32'h0;
  endtask

  initial begin
    rst          = 1'b1;
    stall        = 6'h0;
    flush        = 1'b0;
    if_pc        = 32'h0;
    ex_br_valid  = 1'b0;
    ex_br_taken  = 1'b0;
    ex_br_target = 32'h0;

    do_reset;
    chk("rst_bp",   bp_bus,       33'h0);
    chk("rst_mis",  mis_bus,      33'h0);
    chk("rst_bpex", bp_to_ex_bus, 33'h0);

    branch("a1", 32'h1000, 1'b1, 32'h2000,
           33'h0, {1'b1, 32'h2000});
    branch("a2", 32'h1000, 1'b0, 32'h0,
           {1'b1, 32'h2000}, {1'b1, 32'h1004});
    branch("a3", 32'h1000, 1'b0, 32'h0,
           33'h0, {1'b0, 32'h1004});
    branch("a4", 32'h1000, 1'b1, 32'h2000,
           33'h0, {1'b1, 32'h2000});
`ifdef BPU_SAT_CNT_EN
    branch("a5", 32'h1000, 1'b1, 32'h2000,
           33'h0, {1'b1, 32'h2000});
`else
    branch("a5", 32'h1000, 1'b1, 32'h2000,
           {1'b1, 32'h2000}, {1'b0, 32'h2000});
`endif

    branch("b1", 32'h1100, 1'b1, 32'h2000,
           33'h0, {1'b1, 32'h2000});
    branch("b2", 32'h1100, 1'b1, 32'h3000,
           {1'b1, 32'h2000}, {1'b1, 32'h3000});
    branch("b3", 32'h1100, 1'b1, 32'h3000,
           {1'b1, 32'h3000}, {1'b0, 32'h3000});

    do_reset;
    chk("rst2_bpex", bp_to_ex_bus, 33'h0);
    branch("c1", 32'h100, 1'b1, 32'hA100,
           33'h0, {1'b1, 32'hA100});
    branch("c2", 32'h200, 1'b1, 32'hA200,
           33'h0, {1'b1, 32'hA200});
    branch("c3", 32'h300, 1'b1, 32'hA300,
           33'h0, {1'b1, 32'hA300});
    branch("c4", 32'h400, 1'b1, 32'hA400,
           33'h0, {1'b1, 32'hA400});
    branch("c5", 32'h500, 1'b1, 32'hA500,
           33'h0, {1'b1, 32'hA500});
    branch("c6", 32'h100, 1'b1, 32'hA100,
           33'h0, {1'b1, 32'hA100});
    branch("c7", 32'h500, 1'b1, 32'hA500,
           {1'b1, 32'hA500}, {1'b0, 32'hA500});
    branch("c8", 32'h400, 1'b1, 32'hA400,
           {1'b1, 32'hA400}, {1'b0, 32'hA400});

    if_pc = 32'h500;
    tick;
    chk("d_bp0", bp_bus, {1'b1, 32'hA500});
    if_pc = 32'h400;
    tick;
    chk("d_bp1", bp_bus, {1'b1, 32'hA400});
    if_pc = FILL;
    tick;
    stall = 6'b000100;
    tick;
    chk("d_ex0", bp_to_ex_bus, {1'b1, 32'hA500});
    stall = 6'h0;
    tick;
    chk("d_bubble", bp_to_ex_bus, 33'h0);
    tick;
    chk("d_ex1", bp_to_ex_bus, {1'b1, 32'hA400});

    branch("c9", 32'h200, 1'b1, 32'hA200,
           33'h0, {1'b1, 32'hA200});

    if_pc = 32'h600;
    tick;
    if_pc = 32'h500;
    tick;
    if_pc = 32'h400;
    tick;
    if_pc = 32'h100;
    tick;
    chk("e_bp_pre", bp_bus, {1'b1, 32'hA100});
    chk("e_ex_pre", bp_to_ex_bus, 33'h0);
    ex_br_valid  = 1'b1;
    ex_br_taken  = 1'b1;
    ex_br_target = 32'hA600;
    flush        = 1'b1;
    #1;
    chk("e_mis", mis_bus, 33'h0);
    chk("e_bp",  bp_bus,  33'h0);
    tick;
    flush        = 1'b0;
    ex_br_valid  = 1'b0;
    ex_br_taken  = 1'b0;
    ex_br_target = 32'h0;
    if_pc        = FILL;
    #1;
    chk("e_ex_clr", bp_to_ex_bus, 33'h0);
    chk("e_it_clr", bp_bus,       33'h0);
    branch("e1", 32'h600, 1'b1, 32'hA600,
           33'h0, {1'b1, 32'hA600});

    branch("f1", 32'hFFFF_FFFC, 1'b1, 32'hB000,
           33'h0, {1'b1, 32'hB000});
    branch("f2", 32'hFFFF_FFFC, 1'b0, 32'h0,
           {1'b1, 32'hB000}, {1'b1, 32'h0});
    branch("f3", 32'h600, 1'b1, 32'hA600,
           {1'b1, 32'hA600}, {1'b0, 32'hA600});

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
